// File: rtl/bitscan_pkg.sv
// Shared types and helpers for the bitscan sequencer.
// popcount is only referenced when BITSCAN_COUNT_EN is defined.
package bitscan_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam int POP_MAX_W = 256;

  function automatic int idx_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  function automatic logic [8:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [8:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX_W; i++) c = c + 9'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/bitscan_if.sv
// Input-word and output-beat handshakes of the bitscan sequencer.
// out_remain exists only when BITSCAN_COUNT_EN is defined.
interface bitscan_if import bitscan_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_width(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_number;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_zero;
`ifdef BITSCAN_COUNT_EN
  logic [IDX_W:0]   out_remain;
`endif

  modport master (
    output in_valid, in_number, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_zero
`ifdef BITSCAN_COUNT_EN
    , input out_remain
`endif
  );

  modport slave (
    input  in_valid, in_number, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_zero
`ifdef BITSCAN_COUNT_EN
    , output out_remain
`endif
  );
endinterface

// File: rtl/prio_index_enc.sv
// Combinational priority encoder: index of the highest (MSB_FIRST=1) or
// lowest (MSB_FIRST=0) set bit; idx is 0 and any is 0 for an all-zero vector.
module prio_index_enc import bitscan_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    // Later loop iterations win, so the scan direction sets the priority.
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++)
        if (vec[i]) idx = IDX_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/bitscan_sequencer.sv
// Emits the index of every set bit of an accepted word, one beat per cycle.
// Optional BITSCAN_COUNT_EN adds out_remain (beats left including current).
module bitscan_sequencer import bitscan_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  localparam int IDX_W    = idx_width(WIDTH)
) (
  input logic      clk,
  input logic      rst,
  bitscan_if.slave bus
);

  state_t           state, state_n;
  logic [WIDTH-1:0] rem_p0, rem_n;
  logic             vld_p0, vld_n;
  logic [IDX_W-1:0] idx_p0, idx_n;
  logic             last_p0, last_n;
  logic             zero_p0, zero_n;

  logic [IDX_W-1:0] idx_in, idx_rem;
  logic             any_in, any_rem;
  logic [WIDTH-1:0] clr_in, clr_rem;
  logic             ready, accept, beat;

  prio_index_enc #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_enc_in (
    .vec (bus.in_number),
    .idx (idx_in),
    .any (any_in)
  );

  prio_index_enc #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_enc_rem (
    .vec (rem_p0),
    .idx (idx_rem),
    .any (any_rem)
  );

  assign clr_in  = bus.in_number & ~(WIDTH'(1) << idx_in);
  assign clr_rem = rem_p0 & ~(WIDTH'(1) << idx_rem);

  // A new word may enter while the final beat of the previous one is consumed.
  assign ready  = (state == ST_IDLE) || (vld_p0 && bus.out_ready && last_p0);
  assign accept = bus.in_valid && ready;
  assign beat   = vld_p0 && bus.out_ready;

  always_comb begin
    state_n = state;
    rem_n   = rem_p0;
    vld_n   = vld_p0;
    idx_n   = idx_p0;
    last_n  = last_p0;
    zero_n  = zero_p0;
    if (accept) begin
      state_n = ST_SCAN;
      vld_n   = 1'b1;
      idx_n   = idx_in;
      rem_n   = clr_in;
      last_n  = (clr_in == '0);
      zero_n  = !any_in;
    end else if (beat && last_p0) begin
      state_n = ST_IDLE;
      vld_n   = 1'b0;
      last_n  = 1'b0;
      zero_n  = 1'b0;
    end else if (beat && any_rem) begin
      idx_n  = idx_rem;
      rem_n  = clr_rem;
      last_n = (clr_rem == '0);
    end
  end

  // Stage p0: registered scan state and current beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rem_p0  <= '0;
      vld_p0  <= 1'b0;
      idx_p0  <= '0;
      last_p0 <= 1'b0;
      zero_p0 <= 1'b0;
    end else begin
      state   <= state_n;
      rem_p0  <= rem_n;
      vld_p0  <= vld_n;
      idx_p0  <= idx_n;
      last_p0 <= last_n;
      zero_p0 <= zero_n;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = vld_p0;
  assign bus.out_idx   = idx_p0;
  assign bus.out_last  = last_p0;
  assign bus.out_zero  = zero_p0;

`ifdef BITSCAN_COUNT_EN
  logic [POP_MAX_W-1:0] pop_ext;
  logic [8:0]           pop_full;
  logic [IDX_W:0]       cnt_p0;

  always_comb begin
    pop_ext = '0;
    pop_ext[WIDTH-1:0] = bus.in_number;
  end

  assign pop_full = popcount(pop_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_p0 <= '0;
    else if (accept)
      cnt_p0 <= any_in ? pop_full[IDX_W:0] : (IDX_W+1)'(1);
    else if (beat)
      cnt_p0 <= cnt_p0 - (IDX_W+1)'(1);
  end

  assign bus.out_remain = cnt_p0;
`endif

endmodule
